// File: rtl/riscv_pkg.sv
// Shared RV64I decode constants: opcodes, ALU control and result-source encodings,
// plus the immediate generator and ALU-op helpers used by the decode stage.
package riscv_pkg;

  localparam logic [6:0] OPC_LUI       = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
  localparam logic [6:0] OPC_JAL       = 7'b1101111;
  localparam logic [6:0] OPC_JALR      = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
  localparam logic [6:0] OPC_LOAD      = 7'b0000011;
  localparam logic [6:0] OPC_STORE     = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_OP        = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] OPC_OP_32     = 7'b0111011;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'd0,
    ALU_SUB   = 4'd1,
    ALU_SLL   = 4'd2,
    ALU_SLT   = 4'd3,
    ALU_SLTU  = 4'd4,
    ALU_XOR   = 4'd5,
    ALU_SRL   = 4'd6,
    ALU_SRA   = 4'd7,
    ALU_OR    = 4'd8,
    ALU_AND   = 4'd9,
    ALU_PASSB = 4'd10
  } alu_ctrl_e;

  typedef enum logic [1:0] {
    RES_ALU = 2'b00,
    RES_MEM = 2'b01,
    RES_PC4 = 2'b10
  } result_src_e;

  typedef enum logic [2:0] {
    IMM_NONE = 3'd0,
    IMM_I    = 3'd1,
    IMM_S    = 3'd2,
    IMM_B    = 3'd3,
    IMM_U    = 3'd4,
    IMM_J    = 3'd5
  } imm_sel_e;

  typedef struct packed {
    logic       reg_write;
    logic       mem_write;
    logic       mem_read;
    logic       alu_src;
    logic       alu_src_a;
    logic       word32;
    logic [1:0] result_src;
    logic [3:0] alu_ctrl;
  } ctrl_t;

  // Opcode bits are not needed to build any immediate, so only [31:7] is passed in.
  function automatic logic [63:0] imm_ext(input logic [31:7] ins, input imm_sel_e sel);
    logic [63:0] imm;
    case (sel)
      IMM_I:   imm = {{52{ins[31]}}, ins[31:20]};
      IMM_S:   imm = {{52{ins[31]}}, ins[31:25], ins[11:7]};
      IMM_B:   imm = {{51{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
      IMM_U:   imm = {{32{ins[31]}}, ins[31:12], 12'd0};
      IMM_J:   imm = {{43{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
      default: imm = 64'd0;
    endcase
    return imm;
  endfunction

  // Register forms use bit 30 to pick SUB; immediate forms only use it for SRA.
  function automatic alu_ctrl_e alu_decode(input logic [2:0] funct3, input logic bit30,
                                           input logic is_reg);
    alu_ctrl_e op;
    case (funct3)
      3'b000:  op = (is_reg && bit30) ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = bit30 ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/decode_stage_if.sv
// Fetch/writeback inputs and decode/execute outputs of the decode stage.
// master = upstream/driver side, slave = the decode stage itself.
interface decode_stage_if;
  logic [31:0] InstrD;
  logic [63:0] PCD;
  logic [63:0] PCPlus4D;
  logic        RegWriteW;
  logic [4:0]  RdW;
  logic [63:0] ResultW;

  logic        PCSrcD;
  logic        JalD;
  logic [63:0] PCTargetD;
  logic [63:0] RD1E;
  logic [63:0] RD2E;
  logic [63:0] ImmExtE;
  logic [63:0] PCE;
  logic [63:0] PCPlus4E;
  logic [4:0]  Rs1E;
  logic [4:0]  Rs2E;
  logic [4:0]  RdE;
  logic        RegWriteE;
  logic        MemWriteE;
  logic        MemReadE;
  logic        ALUSrcE;
  logic        ALUSrcAE;
  logic        Word32E;
  logic [1:0]  ResultSrcE;
  logic [3:0]  ALUControlE;
  logic        ValidE;
  logic        IllegalE;

  modport master (
    output InstrD, PCD, PCPlus4D, RegWriteW, RdW, ResultW,
    input  PCSrcD, JalD, PCTargetD, RD1E, RD2E, ImmExtE, PCE, PCPlus4E,
           Rs1E, Rs2E, RdE, RegWriteE, MemWriteE, MemReadE, ALUSrcE, ALUSrcAE,
           Word32E, ResultSrcE, ALUControlE, ValidE, IllegalE
  );

  modport slave (
    input  InstrD, PCD, PCPlus4D, RegWriteW, RdW, ResultW,
    output PCSrcD, JalD, PCTargetD, RD1E, RD2E, ImmExtE, PCE, PCPlus4E,
           Rs1E, Rs2E, RdE, RegWriteE, MemWriteE, MemReadE, ALUSrcE, ALUSrcAE,
           Word32E, ResultSrcE, ALUControlE, ValidE, IllegalE
  );
endinterface

// File: rtl/register_file.sv
// 32x64 integer register file: two combinational read ports with writeback bypass,
// x0 hard-wired to zero, asynchronous active-high reset clears every entry.
module register_file (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  i_rs1,
  input  logic [4:0]  i_rs2,
  output logic [63:0] o_rd1,
  output logic [63:0] o_rd2,
  input  logic        i_we,
  input  logic [4:0]  i_rd,
  input  logic [63:0] i_wd
);

  logic [31:0][63:0] w_regs;

  genvar gi;
  generate
    for (gi = 0; gi < 32; gi++) begin : g_reg
      logic [63:0] r_q;
      // Entry 0 never gets a write enable, so it stays at its reset value of zero.
      always_ff @(posedge clk or posedge rst) begin
        if (rst)
          r_q <= 64'd0;
        else if (i_we && (gi != 0) && (i_rd == 5'(gi)))
          r_q <= i_wd;
      end
      assign w_regs[gi] = r_q;
    end
  endgenerate

  function automatic logic [63:0] read_port(input logic [4:0] idx,
                                            input logic [31:0][63:0] regs,
                                            input logic we, input logic [4:0] wa,
                                            input logic [63:0] wd);
    logic [63:0] val;
    if (idx == 5'd0)
      val = 64'd0;
    else if (we && (wa == idx))
      val = wd;
    else
      val = regs[idx];
    return val;
  endfunction

  always_comb begin
    o_rd1 = read_port(i_rs1, w_regs, i_we, i_rd, i_wd);
    o_rd2 = read_port(i_rs2, w_regs, i_we, i_rd, i_wd);
  end

endmodule

// File: rtl/decode_stage.sv
// RV64I decode stage: control decode, immediates, branch resolution and the D/E register.
// DECODE_ILLEGAL_FLAG_EN defined: illegal opcodes raise IllegalE for one cycle.
module decode_stage
  import riscv_pkg::*;
(
  input logic           clk,
  input logic           rst,
  decode_stage_if.slave bus
);

  logic [31:0] w_instr;
  logic [6:0]  w_opcode;
  logic [2:0]  w_funct3;
  logic [4:0]  w_rs1;
  logic [4:0]  w_rs2;
  logic [4:0]  w_rd;
  logic [63:0] w_rd1;
  logic [63:0] w_rd2;
  logic [63:0] w_imm;
  logic [63:0] w_target;
  imm_sel_e    w_imm_sel;
  ctrl_t       w_ctrl;
  logic        w_legal;
  logic        w_is_branch;
  logic        w_is_jal;
  logic        w_is_jalr;
  logic        w_br_taken;
  logic        w_bubble;
  logic        r_squash;

  logic [63:0] r_rd1, r_rd2, r_imm, r_pc, r_pc4;
  logic [4:0]  r_rs1, r_rs2, r_rd;
  ctrl_t       r_ctrl;
  logic        r_valid;

  assign w_instr  = bus.InstrD;
  assign w_opcode = w_instr[6:0];
  assign w_funct3 = w_instr[14:12];
  assign w_rs1    = w_instr[19:15];
  assign w_rs2    = w_instr[24:20];
  assign w_rd     = w_instr[11:7];

  register_file u_regfile (
    .clk   (clk),
    .rst   (rst),
    .i_rs1 (w_rs1),
    .i_rs2 (w_rs2),
    .o_rd1 (w_rd1),
    .o_rd2 (w_rd2),
    .i_we  (bus.RegWriteW),
    .i_rd  (bus.RdW),
    .i_wd  (bus.ResultW)
  );

  always_comb begin
    w_ctrl          = '0;
    w_ctrl.alu_ctrl = ALU_ADD;
    w_imm_sel       = IMM_NONE;
    w_legal         = 1'b1;
    w_is_branch     = 1'b0;
    w_is_jal        = 1'b0;
    w_is_jalr       = 1'b0;
    case (w_opcode)
      OPC_LUI: begin
        w_imm_sel = IMM_U; w_ctrl.reg_write = 1'b1; w_ctrl.alu_src = 1'b1;
        w_ctrl.alu_ctrl = ALU_PASSB;
      end
      OPC_AUIPC: begin
        w_imm_sel = IMM_U; w_ctrl.reg_write = 1'b1; w_ctrl.alu_src = 1'b1;
        w_ctrl.alu_src_a = 1'b1;
      end
      OPC_JAL: begin
        w_imm_sel = IMM_J; w_ctrl.reg_write = 1'b1; w_ctrl.result_src = RES_PC4;
        w_is_jal = 1'b1;
      end
      OPC_JALR: begin
        w_imm_sel = IMM_I; w_ctrl.reg_write = 1'b1; w_ctrl.result_src = RES_PC4;
        w_ctrl.alu_src = 1'b1; w_is_jalr = 1'b1;
      end
      OPC_BRANCH: begin
        w_imm_sel = IMM_B; w_is_branch = 1'b1;
      end
      OPC_LOAD: begin
        w_imm_sel = IMM_I; w_ctrl.reg_write = 1'b1; w_ctrl.mem_read = 1'b1;
        w_ctrl.alu_src = 1'b1; w_ctrl.result_src = RES_MEM;
      end
      OPC_STORE: begin
        w_imm_sel = IMM_S; w_ctrl.mem_write = 1'b1; w_ctrl.alu_src = 1'b1;
      end
      OPC_OP_IMM, OPC_OP_IMM_32: begin
        w_imm_sel = IMM_I; w_ctrl.reg_write = 1'b1; w_ctrl.alu_src = 1'b1;
        w_ctrl.alu_ctrl = alu_decode(w_funct3, w_instr[30], 1'b0);
        w_ctrl.word32 = (w_opcode == OPC_OP_IMM_32);
      end
      OPC_OP, OPC_OP_32: begin
        w_ctrl.reg_write = 1'b1;
        w_ctrl.alu_ctrl = alu_decode(w_funct3, w_instr[30], 1'b1);
        w_ctrl.word32 = (w_opcode == OPC_OP_32);
      end
      default: w_legal = 1'b0;
    endcase
  end

  assign w_imm = imm_ext(w_instr[31:7], w_imm_sel);

  always_comb begin
    case (w_funct3)
      3'b000:  w_br_taken = (w_rd1 == w_rd2);
      3'b001:  w_br_taken = (w_rd1 != w_rd2);
      3'b100:  w_br_taken = ($signed(w_rd1) <  $signed(w_rd2));
      3'b101:  w_br_taken = ($signed(w_rd1) >= $signed(w_rd2));
      3'b110:  w_br_taken = (w_rd1 <  w_rd2);
      3'b111:  w_br_taken = (w_rd1 >= w_rd2);
      default: w_br_taken = 1'b0;
    endcase
  end

  assign w_target      = w_is_jalr ? ((w_rd1 + w_imm) & ~64'd1) : (bus.PCD + w_imm);
  assign bus.PCTargetD = w_target;
  // A squashed slot is the wrong-path instruction behind a redirect and must not redirect again.
  assign bus.PCSrcD    = ~r_squash & ((w_is_branch & w_br_taken) | w_is_jalr);
  assign bus.JalD      = ~r_squash & w_is_jal;
  assign w_bubble      = r_squash | ~w_legal | (w_instr == 32'd0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_squash <= 1'b0;
    else
      r_squash <= bus.PCSrcD | bus.JalD;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd1 <= '0; r_rd2 <= '0; r_imm <= '0; r_pc <= '0; r_pc4 <= '0;
      r_rs1 <= '0; r_rs2 <= '0; r_rd  <= '0;
      r_ctrl <= '0; r_valid <= 1'b0;
    end else begin
      r_rd1 <= w_rd1; r_rd2 <= w_rd2; r_imm <= w_imm;
      r_pc  <= bus.PCD; r_pc4 <= bus.PCPlus4D;
      r_rs1 <= w_rs1; r_rs2 <= w_rs2; r_rd <= w_rd;
      r_ctrl <= w_ctrl;
      r_valid <= ~w_bubble;
      if (w_bubble) begin
        r_ctrl.reg_write <= 1'b0;
        r_ctrl.mem_write <= 1'b0;
        r_ctrl.mem_read  <= 1'b0;
      end
    end
  end

`ifdef DECODE_ILLEGAL_FLAG_EN
  logic r_illegal;
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_illegal <= 1'b0;
    else
      r_illegal <= ~r_squash & ~w_legal & (w_instr != 32'd0);
  end
  assign bus.IllegalE = r_illegal;
`else
  assign bus.IllegalE = 1'b0;
`endif

  assign bus.RD1E        = r_rd1;
  assign bus.RD2E        = r_rd2;
  assign bus.ImmExtE     = r_imm;
  assign bus.PCE         = r_pc;
  assign bus.PCPlus4E    = r_pc4;
  assign bus.Rs1E        = r_rs1;
  assign bus.Rs2E        = r_rs2;
  assign bus.RdE         = r_rd;
  assign bus.RegWriteE   = r_ctrl.reg_write;
  assign bus.MemWriteE   = r_ctrl.mem_write;
  assign bus.MemReadE    = r_ctrl.mem_read;
  assign bus.ALUSrcE     = r_ctrl.alu_src;
  assign bus.ALUSrcAE    = r_ctrl.alu_src_a;
  assign bus.Word32E     = r_ctrl.word32;
  assign bus.ResultSrcE  = r_ctrl.result_src;
  assign bus.ALUControlE = r_ctrl.alu_ctrl;
  assign bus.ValidE      = r_valid;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: table of single-instruction vectors plus
// hand sequences for bypass, squash, jumps, x0 and asynchronous reset.
module tb_decode_stage;
  import riscv_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  decode_stage_if dif();

  decode_stage u_dut (
    .clk (clk),
    .rst (rst),
    .bus (dif.slave)
  );

  int n_tests = 0;
  int n_fail  = 0;

  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;
`ifdef DECODE_ILLEGAL_FLAG_EN
  localparam logic ILL = 1'b1;
`else
  localparam logic ILL = 1'b0;
`endif

  // ctl = {ValidE, RegWriteE, MemWriteE, MemReadE, ALUSrcE, ALUSrcAE, Word32E}
  typedef struct {
    logic [31:0] instr;
    logic [63:0] rd1;
    logic [63:0] rd2;
    logic [63:0] imm;
    logic [4:0]  rd;
    logic [3:0]  alu;
    logic [1:0]  rsrc;
    logic [6:0]  ctl;
    logic        ill;
    logic        chk_tgt;
    logic [63:0] tgt_off;
  } vec_t;

  vec_t vecs [12];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] instr, input logic [63:0] pc);
    dif.InstrD   = instr;
    dif.PCD      = pc;
    dif.PCPlus4D = pc + 64'd4;
  endtask

  task automatic wr(input logic [4:0] rd, input logic [63:0] val);
    dif.RegWriteW = 1'b1;
    dif.RdW       = rd;
    dif.ResultW   = val;
    tick();
    dif.RegWriteW = 1'b0;
    $display("[TB] wb x%0d <= %h", rd, val);
  endtask

  initial begin
    logic [63:0] pc;
    dif.InstrD = 32'd0; dif.PCD = 64'd0; dif.PCPlus4D = 64'd4;
    dif.RegWriteW = 1'b0; dif.RdW = 5'd0; dif.ResultW = 64'd0;

    vecs[0]  = '{32'h00718213, 64'h5,  64'h1,  64'h7,  5'd4,  ALU_ADD,   2'b00, 7'h64, 1'b0, 1'b0, 64'd0};
    vecs[1]  = '{32'h40208433, 64'h10, 64'h10, 64'h0,  5'd8,  ALU_SUB,   2'b00, 7'h60, 1'b0, 1'b0, 64'd0};
    vecs[2]  = '{32'hFFF3049B, ONES,   64'h0,  ONES,   5'd9,  ALU_ADD,   2'b00, 7'h65, 1'b0, 1'b0, 64'd0};
    vecs[3]  = '{32'hFE20BC23, 64'h10, 64'h10, 64'hFFFF_FFFF_FFFF_FFF8, 5'd24, ALU_ADD, 2'b00, 7'h54, 1'b0, 1'b0, 64'd0};
    vecs[4]  = '{32'h0102B503, 64'h201, 64'h0, 64'h10, 5'd10, ALU_ADD,   2'b01, 7'h6C, 1'b0, 1'b0, 64'd0};
    vecs[5]  = '{32'h123455B7, 64'h0,  64'h5,  64'h12345000, 5'd11, ALU_PASSB, 2'b00, 7'h64, 1'b0, 1'b0, 64'd0};
    vecs[6]  = '{32'h00001617, 64'h0,  64'h0,  64'h1000, 5'd12, ALU_ADD,  2'b00, 7'h66, 1'b0, 1'b0, 64'd0};
    vecs[7]  = '{32'h00608863, 64'h10, ONES,   64'h10, 5'd16, ALU_ADD,   2'b00, 7'h40, 1'b0, 1'b1, 64'd16};
    vecs[8]  = '{32'h40335693, ONES,   64'h5,  64'h403, 5'd13, ALU_SRA,  2'b00, 7'h64, 1'b0, 1'b0, 64'd0};
    vecs[9]  = '{32'h0070C733, 64'h10, 64'h1,  64'h0,  5'd14, ALU_XOR,   2'b00, 7'h60, 1'b0, 1'b0, 64'd0};
    vecs[10] = '{32'h0000007F, 64'h0,  64'h0,  64'h0,  5'd0,  ALU_ADD,   2'b00, 7'h00, ILL,  1'b0, 64'd0};
    vecs[11] = '{32'h00000000, 64'h0,  64'h0,  64'h0,  5'd0,  ALU_ADD,   2'b00, 7'h00, 1'b0, 1'b0, 64'd0};

    // Asynchronous reset, checked away from any clock edge
    #2 rst = 1'b1;
    #2;
    chk("rst_ValidE", dif.ValidE, 1'b0);
    chk("rst_RegWriteE", dif.RegWriteE, 1'b0);
    chk("rst_RD1E", dif.RD1E, 64'd0);
    chk("rst_PCE", dif.PCE, 64'd0);
    chk("rst_IllegalE", dif.IllegalE, 1'b0);
    tick();
    rst = 1'b0;
    $display("[TB] reset released");

    wr(5'd1, 64'h10); wr(5'd2, 64'h10); wr(5'd3, 64'h5);
    wr(5'd5, 64'h201); wr(5'd6, ONES); wr(5'd7, 64'h1);

    for (int i = 0; i < 12; i++) begin
      pc = 64'h1000 + 64'(4 * i);
      drive(vecs[i].instr, pc);
      #1;
      chk($sformatf("v%0d_PCSrcD", i), dif.PCSrcD, 1'b0);
      chk($sformatf("v%0d_JalD", i), dif.JalD, 1'b0);
      if (vecs[i].chk_tgt)
        chk($sformatf("v%0d_PCTargetD", i), dif.PCTargetD, pc + vecs[i].tgt_off);
      tick();
      chk($sformatf("v%0d_RD1E", i), dif.RD1E, vecs[i].rd1);
      chk($sformatf("v%0d_RD2E", i), dif.RD2E, vecs[i].rd2);
      chk($sformatf("v%0d_ImmExtE", i), dif.ImmExtE, vecs[i].imm);
      chk($sformatf("v%0d_RdE", i), 64'(dif.RdE), 64'(vecs[i].rd));
      chk($sformatf("v%0d_ALUControlE", i), 64'(dif.ALUControlE), 64'(vecs[i].alu));
      chk($sformatf("v%0d_ResultSrcE", i), 64'(dif.ResultSrcE), 64'(vecs[i].rsrc));
      chk($sformatf("v%0d_ctl", i),
          64'({dif.ValidE, dif.RegWriteE, dif.MemWriteE, dif.MemReadE,
               dif.ALUSrcE, dif.ALUSrcAE, dif.Word32E}), 64'(vecs[i].ctl));
      chk($sformatf("v%0d_IllegalE", i), dif.IllegalE, vecs[i].ill);
      chk($sformatf("v%0d_PCE", i), dif.PCE, pc);
      $display("[TB] vec %0d instr=%08h ValidE=%0b RD1E=%h ImmExtE=%h",
               i, vecs[i].instr, dif.ValidE, dif.RD1E, dif.ImmExtE);
    end

    // Same-cycle writeback bypass: ADDI x4,x15,7 while x15 <= 0x77
    dif.RegWriteW = 1'b1; dif.RdW = 5'd15; dif.ResultW = 64'h77;
    drive(32'h00778213, 64'h2000);
    tick();
    dif.RegWriteW = 1'b0;
    chk("byp_RD1E", dif.RD1E, 64'h77);
    chk("byp_Rs1E", 64'(dif.Rs1E), 64'd15);
    chk("byp_Rs2E", 64'(dif.Rs2E), 64'd7);
    $display("[TB] bypass ADDI x4,x15,7 RD1E=%h", dif.RD1E);

    // x0 is never written, not even via the bypass path
    dif.RegWriteW = 1'b1; dif.RdW = 5'd0; dif.ResultW = 64'hFF;
    drive(32'h00000213, 64'h2004);
    tick();
    dif.RegWriteW = 1'b0;
    chk("x0_byp_RD1E", dif.RD1E, 64'd0);
    tick();
    chk("x0_RD1E", dif.RD1E, 64'd0);
    $display("[TB] x0 write of FF, RD1E=%h", dif.RD1E);

    // Taken BEQ redirects; the following slot is squashed but writeback still lands
    drive(32'h00208863, 64'h100);
    #1;
    chk("beq_PCSrcD", dif.PCSrcD, 1'b1);
    chk("beq_PCTargetD", dif.PCTargetD, 64'h110);
    tick();
    chk("beq_ValidE", dif.ValidE, 1'b1);
    dif.RegWriteW = 1'b1; dif.RdW = 5'd20; dif.ResultW = 64'hAB;
    drive(32'h00208863, 64'h104);
    #1;
    chk("sq_PCSrcD", dif.PCSrcD, 1'b0);
    tick();
    dif.RegWriteW = 1'b0;
    chk("sq_ValidE", dif.ValidE, 1'b0);
    chk("sq_RegWriteE", dif.RegWriteE, 1'b0);
    drive(32'h000A0213, 64'h108);
    tick();
    chk("post_sq_ValidE", dif.ValidE, 1'b1);
    chk("post_sq_RD1E", dif.RD1E, 64'hAB);
    $display("[TB] beq taken, squash, x20=%h", dif.RD1E);

    // Signed vs unsigned compare of -1 and 1
    drive(32'h00734863, 64'h200);
    #1;
    chk("blt_PCSrcD", dif.PCSrcD, 1'b1);
    chk("blt_PCTargetD", dif.PCTargetD, 64'h210);
    tick();
    drive(32'h00000000, 64'h204);
    tick();
    drive(32'h00736863, 64'h210);
    #1;
    chk("bltu_PCSrcD", dif.PCSrcD, 1'b0);
    tick();
    chk("bltu_ValidE", dif.ValidE, 1'b1);
    $display("[TB] blt/bltu done");

    // JALR x1,8(x5) with x5=0x201
    drive(32'h008280E7, 64'h400);
    #1;
    chk("jalr_PCSrcD", dif.PCSrcD, 1'b1);
    chk("jalr_JalD", dif.JalD, 1'b0);
    chk("jalr_PCTargetD", dif.PCTargetD, 64'h208);
    tick();
    chk("jalr_ResultSrcE", 64'(dif.ResultSrcE), 64'd2);
    chk("jalr_RdE", 64'(dif.RdE), 64'd1);
    chk("jalr_RegWriteE", dif.RegWriteE, 1'b1);
    drive(32'h00000000, 64'h404);
    tick();
    $display("[TB] jalr done");

    // JAL x1,+0x20
    drive(32'h020000EF, 64'h300);
    #1;
    chk("jal_JalD", dif.JalD, 1'b1);
    chk("jal_PCSrcD", dif.PCSrcD, 1'b0);
    chk("jal_PCTargetD", dif.PCTargetD, 64'h320);
    tick();
    chk("jal_ResultSrcE", 64'(dif.ResultSrcE), 64'd2);
    chk("jal_RegWriteE", dif.RegWriteE, 1'b1);
    chk("jal_PCPlus4E", dif.PCPlus4E, 64'h304);
    drive(32'h00000000, 64'h304);
    tick();
    $display("[TB] jal done");

    // Reset pulse while a squash is pending
    drive(32'h00208863, 64'h100);
    #1;
    chk("rbeq_PCSrcD", dif.PCSrcD, 1'b1);
    tick();
    rst = 1'b1;
    #1;
    chk("mrst_ValidE", dif.ValidE, 1'b0);
    chk("mrst_RD1E", dif.RD1E, 64'd0);
    chk("mrst_ImmExtE", dif.ImmExtE, 64'd0);
    chk("mrst_PCE", dif.PCE, 64'd0);
    chk("mrst_RdE", 64'(dif.RdE), 64'd0);
    rst = 1'b0;
    drive(32'h00008213, 64'h500);
    tick();
    chk("prst_ValidE", dif.ValidE, 1'b1);
    chk("prst_RegWriteE", dif.RegWriteE, 1'b1);
    chk("prst_RD1E", dif.RD1E, 64'd0);
    $display("[TB] mid-stream reset done");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 clk  input  1  rising-edge clock for all state.
REQ-002 rst  input  1  reset; asynchronous, active-high.
REQ-003 InstrD  input  32  instruction from fetch register; 0x00000000 is a bubble.
REQ-004 PCD / PCPlus4D  input  64 each  PC and PC+4 of InstrD.
REQ-005 RegWriteW / RdW / ResultW  input  1/5/64  writeback port.
REQ-006 PCSrcD  output  1  combinational: taken branch or JALR.
REQ-007 JalD  output  1  combinational: JAL.
REQ-008 PCTargetD  output  64  combinational redirect target.
REQ-009 RD1E, RD2E, ImmExtE, PCE, PCPlus4E  output  64 each  registered operands and PCs.
REQ-010 Rs1E, Rs2E, RdE  output  5 each  registered register indices.
REQ-011 RegWriteE, MemWriteE, MemReadE, ALUSrcE, ALUSrcAE, Word32E  output  1 each  registered controls; ALUSrcAE selects PC as operand A; Word32E marks OP-32 / OP-IMM-32.
REQ-012 ResultSrcE  output  2  00 ALU, 01 memory, 10 PC+4.
REQ-013 ALUControlE  output  4  encoding from shared package.
REQ-014 ValidE  output  1  registered: E holds a real instruction.
REQ-015 IllegalE  output  1  registered illegal-opcode flag (see Configuration).

Function
REQ-016 Register file: 32x64; x0 reads 0; write at posedge when RegWriteW and RdW!=0.
REQ-017 Read bypass: same-cycle write to the read index returns ResultW.
REQ-018 Decode RV64I opcodes LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP-IMM, OP, OP-IMM-32, OP-32; all else illegal.
REQ-019 Immediates I/S/B/U/J sign-extended to 64 bits.
REQ-020 Branch compare on bypassed RD1/RD2: BEQ, BNE, BLT, BGE signed; BLTU, BGEU unsigned.
REQ-021 PCTargetD: PCD+imm for branch/JAL; (RD1+imm) & ~1 for JALR.
REQ-022 JAL and JALR: RegWriteE=1, ResultSrcE=10.
REQ-023 Squash flag: set at posedge when PCSrcD|JalD asserted; otherwise cleared.
REQ-024 Squash set: current InstrD is wrong-path; PCSrcD=JalD=0, regfile write port unaffected.
REQ-025 Bubble (squash, InstrD=0, or illegal): E loads ValidE=0 and RegWriteE=MemWriteE=MemReadE=0.
REQ-026 Latency: E outputs valid one cycle after InstrD; redirect same cycle as InstrD.
REQ-027 Hazards against E/M are outside scope; compare uses only regfile plus W bypass.

Reset
REQ-028 rst asynchronously clears every E output, squash flag and all 32 registers to 0.
REQ-029 Deassertion: first InstrD decoded normally (squash clear).
REQ-030 rst mid-redirect: pending squash discarded.

Configuration
REQ-031 Macro DECODE_ILLEGAL_FLAG_EN defined: illegal opcode gives bubble with IllegalE=1 for one cycle.
REQ-032 Macro undefined: illegal opcode gives silent bubble; IllegalE tied 0; InstrD=0 never flags.

Structure
REQ-033 Package riscv_pkg: opcode constants, ALUControl encodings, ResultSrc encodings.
REQ-034 Sub-module register_file (REQ-016/017, own async reset); decode logic and E register in decode_stage.

Verification
REQ-035 ResultW=0x5, RdW=3 write, then ADDI x4,x3,7 -> next cycle RD1E=5, ImmExtE=7, RdE=4, ALUControlE=ADD, ValidE=1.
REQ-036 x1=x2=0x10, BEQ x1,x2,+16 at PCD=0x100 -> PCSrcD=1, PCTargetD=0x110; next InstrD squashed (ValidE=0, PCSrcD=0).
REQ-037 x1=-1, x2=1: BLT taken, BLTU not taken -> PCSrcD 1 then 0.
REQ-038 JALR x1,8(x5), x5=0x201 -> PCTargetD=0x208, ResultSrcE=10, RdE=1.
REQ-039 RdW=0 write of 0xFF -> x0 reads 0; InstrD=0 -> ValidE=0, IllegalE=0.
REQ-040 rst pulse mid-stream after taken branch -> all E outputs 0, regs 0, first post-reset instruction not squashed.
